stage_tracker: RTL and testbench

STAGE_TRACKER -- requirements
Module: stage_tracker

---
 rtl/stage_tracker.sv | 265 ++++++++++++++++++++++++++
 tb/tb_stage_tracker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_tracker.sv
// stage_tracker: buffers elements and pairs each one with a completion strobe of the
// tracked stage to report its start/end cycles. Define STAGE_TRACKER_TIMEOUT_EN to bound WAIT.
module stage_tracker #(
    parameter int COUNT_WIDTH    = 32,
    parameter int TAG_WIDTH      = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int HIST_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COUNT_WIDTH-1:0] counter,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_pass_through,
    input  logic [COUNT_WIDTH-1:0] in_time_end,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    input  logic                   stage_ready,
    output logic                   out_valid,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic                   out_pass_through,
    output logic [COUNT_WIDTH-1:0] out_time_start,
    output logic [COUNT_WIDTH-1:0] out_time_end,
    output logic                   out_stale,
    output logic                   out_timeout,
    output logic                   overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(HIST_DEPTH + 1);
    localparam logic [COUNT_WIDTH-1:0] HIST_SPAN = COUNT_WIDTH'(HIST_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || HIST_DEPTH < 2 ||
        HIST_DEPTH > 64 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("stage_tracker: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, EVAL, WAIT, OUTPUT} state_e;

    typedef struct packed {
        logic                   pass_through;
        logic [COUNT_WIDTH-1:0] time_end;
        logic [TAG_WIDTH-1:0]   tag;
    } elem_t;

    state_e                 state_q, state_d;
    elem_t                  mem_q [FIFO_DEPTH];
    elem_t                  mem_d [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [HIST_DEPTH-1:0]  hist_q, hist_d;
    elem_t                  work_q, work_d;
    logic                   work_stale_q, work_stale_d;
    logic [COUNT_WIDTH-1:0] last_claim_q, last_claim_d;
    logic                   has_claim_q, has_claim_d;
    logic                   overflow_q, overflow_d;
    logic                   out_valid_q, out_valid_d;
    logic [TAG_WIDTH-1:0]   out_tag_q, out_tag_d;
    logic                   out_pt_q, out_pt_d;
    logic [COUNT_WIDTH-1:0] out_start_q, out_start_d, out_end_q, out_end_d;
    logic                   out_stale_q, out_stale_d;
`ifdef STAGE_TRACKER_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
    logic                   out_timeout_q, out_timeout_d;
    logic                   res_timeout;
`endif

    logic                   full, push, pop, finish, res_stale;
    logic [COUNT_WIDTH-1:0] res_end;
    logic [COUNT_WIDTH-1:0] age_e, since_claim, hit_end;
    logic [LW-1:0]          win_lim, claim_lim, search_lim, hit_idx;
    logic                   hit, stale_now, ready_now;

    assign full = (count_q == (AW+1)'(FIFO_DEPTH));

    // History search: bit i is the strobe of cycle counter-1-i; pick the oldest bit that lies
    // after E, inside the look-back window and after the last claimed strobe.
    always_comb begin
        age_e       = counter - work_q.time_end - COUNT_WIDTH'(1);
        since_claim = counter - last_claim_q;
        stale_now   = 1'b0;
        if (age_e[COUNT_WIDTH-1]) begin
            win_lim = '0;
        end else if (age_e > HIST_SPAN) begin
            win_lim   = LW'(HIST_DEPTH);
            stale_now = 1'b1;
        end else begin
            win_lim = age_e[LW-1:0];
        end
        if (!has_claim_q || since_claim > HIST_SPAN) claim_lim = LW'(HIST_DEPTH);
        else if (since_claim == '0)                  claim_lim = '0;
        else                                         claim_lim = LW'(since_claim - COUNT_WIDTH'(1));
        search_lim = (win_lim < claim_lim) ? win_lim : claim_lim;
        hit        = 1'b0;
        hit_idx    = '0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (hist_q[i] && LW'(i) < search_lim) begin
                hit     = 1'b1;
                hit_idx = LW'(i);
            end
        end
        hit_end   = counter - COUNT_WIDTH'(hit_idx) - COUNT_WIDTH'(1);
        ready_now = stage_ready && (!has_claim_q || since_claim != '0);
    end

    // NOTE: every _d starts from its _q (or a fixed default), so no path can infer a latch.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        hist_d       = {hist_q[HIST_DEPTH-2:0], stage_ready};
        state_d      = state_q;
        work_d       = work_q;
        work_stale_d = work_stale_q;
        last_claim_d = last_claim_q;
        has_claim_d  = has_claim_q;
        overflow_d   = overflow_q || (in_valid && full);
        out_valid_d  = 1'b0;
        out_tag_d    = out_tag_q;
        out_pt_d     = out_pt_q;
        out_start_d  = out_start_q;
        out_end_d    = out_end_q;
        out_stale_d  = out_stale_q;
        finish       = 1'b0;
        res_end      = counter;
        res_stale    = 1'b0;
`ifdef STAGE_TRACKER_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        out_timeout_d = out_timeout_q;
        res_timeout   = 1'b0;
`endif
        push = in_valid && !full;
        pop  = (state_q == IDLE) && (count_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = '{pass_through: in_pass_through, time_end: in_time_end, tag: in_tag};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

        case (state_q)
            IDLE: begin
                if (pop) begin
                    work_d  = mem_q[rd_ptr_q];
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (work_q.pass_through) begin
                    finish  = 1'b1;
                    res_end = work_q.time_end;
                end else if (hit || ready_now) begin
                    finish    = 1'b1;
                    res_end   = hit ? hit_end : counter;
                    res_stale = stale_now;
                end else begin
                    state_d      = WAIT;
                    work_stale_d = stale_now;
`ifdef STAGE_TRACKER_TIMEOUT_EN
                    wait_cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (stage_ready) begin
                    finish    = 1'b1;
                    res_stale = work_stale_q;
`ifdef STAGE_TRACKER_TIMEOUT_EN
                end else if (wait_cnt_q == WCW'(TIMEOUT_CYCLES - 1)) begin
                    finish      = 1'b1;
                    res_stale   = work_stale_q;
                    res_timeout = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d     = OUTPUT;
            out_valid_d = 1'b1;
            out_tag_d   = work_q.tag;
            out_pt_d    = work_q.pass_through;
            out_start_d = work_q.pass_through ? work_q.time_end : work_q.time_end + COUNT_WIDTH'(1);
            out_end_d   = res_end;
            out_stale_d = res_stale;
`ifdef STAGE_TRACKER_TIMEOUT_EN
            out_timeout_d = res_timeout;
`endif
            if (!work_q.pass_through) begin
                last_claim_d = res_end;
                has_claim_d  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge value of its _d.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hist_q       <= '0;
            work_q       <= '0;
            work_stale_q <= 1'b0;
            last_claim_q <= '1;
            has_claim_q  <= 1'b0;
            overflow_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_tag_q    <= '0;
            out_pt_q     <= 1'b0;
            out_start_q  <= '0;
            out_end_q    <= '0;
            out_stale_q  <= 1'b0;
`ifdef STAGE_TRACKER_TIMEOUT_EN
            wait_cnt_q    <= '0;
            out_timeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hist_q       <= hist_d;
            work_q       <= work_d;
            work_stale_q <= work_stale_d;
            last_claim_q <= last_claim_d;
            has_claim_q  <= has_claim_d;
            overflow_q   <= overflow_d;
            out_valid_q  <= out_valid_d;
            out_tag_q    <= out_tag_d;
            out_pt_q     <= out_pt_d;
            out_start_q  <= out_start_d;
            out_end_q    <= out_end_d;
            out_stale_q  <= out_stale_d;
`ifdef STAGE_TRACKER_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            out_timeout_q <= out_timeout_d;
`endif
        end
    end

    // NOTE: buffer storage has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign in_ready         = !full;
    assign overflow         = overflow_q;
    assign out_valid        = out_valid_q;
    assign out_tag          = out_tag_q;
    assign out_pass_through = out_pt_q;
    assign out_time_start   = out_start_q;
    assign out_time_end     = out_end_q;
    assign out_stale        = out_stale_q;
`ifdef STAGE_TRACKER_TIMEOUT_EN
    assign out_timeout = out_timeout_q;
`else
    assign out_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_stage_tracker.sv
// Self-checking bench for stage_tracker: directed scenarios plus randomized traffic,
// all compared against a transaction-level model that works in absolute cycle numbers.
module tb_stage_tracker;
    localparam int CW   = 32;
    localparam int TW   = 16;
    localparam int FD   = 4;
    localparam int HD   = 16;
    localparam int TO   = 8;
    localparam int MAXN = 420;
    localparam int NEVER = 1 << 30;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] counter;
    logic          in_valid, in_ready, in_pass_through, stage_ready;
    logic [CW-1:0] in_time_end;
    logic [TW-1:0] in_tag;
    logic          out_valid, out_pass_through, out_stale, out_timeout, overflow;
    logic [TW-1:0] out_tag;
    logic [CW-1:0] out_time_start, out_time_end;

    always #5 clk = ~clk;

    stage_tracker #(
        .COUNT_WIDTH(CW), .TAG_WIDTH(TW), .FIFO_DEPTH(FD), .HIST_DEPTH(HD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .counter(counter),
        .in_valid(in_valid), .in_ready(in_ready), .in_pass_through(in_pass_through),
        .in_time_end(in_time_end), .in_tag(in_tag), .stage_ready(stage_ready),
        .out_valid(out_valid), .out_tag(out_tag), .out_pass_through(out_pass_through),
        .out_time_start(out_time_start), .out_time_end(out_time_end),
        .out_stale(out_stale), .out_timeout(out_timeout), .overflow(overflow)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus, per cycle t relative to reset release; times are relative to base.
    logic [CW-1:0] base;
    int            n;
    bit            s_valid [MAXN];
    bit            s_pt    [MAXN];
    int            s_end   [MAXN];
    logic [TW-1:0] s_tag   [MAXN];
    bit            s_rdy   [MAXN];

    typedef struct {
        bit            valid;
        logic [TW-1:0] tag;
        bit            pt;
        int            t_start;
        int            t_end;
        bit            stale;
        bit            tmo;
    } res_t;
    res_t e_out   [MAXN];
    bit   e_ready [MAXN];
    bit   e_ovf   [MAXN];

    logic          obs_valid [MAXN];
    logic          obs_pt    [MAXN];
    logic          obs_stale [MAXN];
    logic          obs_tmo   [MAXN];
    logic          obs_ovf   [MAXN];
    logic          obs_rdy   [MAXN];
    logic [CW-1:0] obs_start [MAXN];
    logic [CW-1:0] obs_end   [MAXN];

    function automatic logic [CW-1:0] abs_c(input int rel);
        abs_c = base + CW'(rel);
    endfunction

    function automatic bit rdy(input int c);
        rdy = (c >= 0 && c < n) ? s_rdy[c] : 1'b0;
    endfunction

    task automatic clear(input int len, input logic [CW-1:0] b);
        n    = len;
        base = b;
        for (int i = 0; i < MAXN; i++) begin
            s_valid[i] = 0; s_pt[i] = 0; s_end[i] = 0; s_tag[i] = '0; s_rdy[i] = 0;
        end
    endtask

    // Server model: one element in flight; popped when the server is idle, evaluated the
    // next cycle, reported the cycle after its end is known.
    task automatic build_model();
        int q[$];
        int busy_until, last_claim, p, ev, e, lo, t_end, done_at;
        bit claimed, ovf, found, stale, tmo;
        busy_until = 0; last_claim = 0; claimed = 0; ovf = 0;
        for (int t = 0; t < n; t++) e_out[t].valid = 0;
        for (int t = 0; t < n; t++) begin
            e_ready[t] = (q.size() < FD);
            e_ovf[t]   = ovf;
            if (t >= busy_until && q.size() > 0) begin
                p = q.pop_front();
                ev = t + 1; e = s_end[p]; stale = 0; tmo = 0; found = 0; t_end = 0;
                done_at = NEVER;
                if (s_pt[p]) begin
                    found = 1; t_end = e; done_at = ev + 1;
                end else begin
                    stale = (ev - e - 1) > HD;
                    lo = (e + 1 > ev - HD) ? e + 1 : ev - HD;
                    for (int c = lo; c < ev; c++)
                        if (!found && rdy(c) && (!claimed || c > last_claim)) begin
                            found = 1; t_end = c;
                        end
                    if (!found && rdy(ev)) begin found = 1; t_end = ev; end
                    if (found) done_at = ev + 1;
                    for (int w = ev + 1; w < n && !found; w++) begin
                        if (rdy(w)) begin
                            found = 1; t_end = w; done_at = w + 1;
                        end
`ifdef STAGE_TRACKER_TIMEOUT_EN
                        else if (w - ev == TO) begin
                            found = 1; tmo = 1; t_end = w; done_at = w + 1;
                        end
`endif
                    end
                    if (found) begin claimed = 1; last_claim = t_end; end
                end
                busy_until = (done_at == NEVER) ? NEVER : done_at + 1;
                if (done_at < n)
                    e_out[done_at] = '{1'b1, s_tag[p], s_pt[p], s_pt[p] ? e : e + 1, t_end, stale, tmo};
            end
            if (s_valid[t]) begin
                if (e_ready[t]) q.push_back(t);
                else            ovf = 1;
            end
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0; in_valid = 0; stage_ready = 0; in_pass_through = 0;
        in_time_end = '0; in_tag = '0; counter = base - CW'(1);
        #1;
        check("rst.out_valid", out_valid, 0);
        check("rst.in_ready", in_ready, 1);
        check("rst.overflow", overflow, 0);
        check("rst.fields", {out_tag, out_pass_through, out_time_start, out_time_end, out_stale, out_timeout}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_phase(input string name);
        build_model();
        for (int t = 0; t < n; t++) begin
            obs_valid[t] = out_valid; obs_pt[t] = out_pass_through; obs_stale[t] = out_stale;
            obs_tmo[t] = out_timeout; obs_ovf[t] = overflow; obs_rdy[t] = in_ready;
            obs_start[t] = out_time_start; obs_end[t] = out_time_end;
            check($sformatf("%s.valid@%0d", name, t), out_valid, e_out[t].valid);
            check($sformatf("%s.in_ready@%0d", name, t), in_ready, e_ready[t]);
            check($sformatf("%s.overflow@%0d", name, t), overflow, e_ovf[t]);
            if (e_out[t].valid) begin
                check($sformatf("%s.tag@%0d", name, t), out_tag, e_out[t].tag);
                check($sformatf("%s.pt@%0d", name, t), out_pass_through, e_out[t].pt);
                check($sformatf("%s.start@%0d", name, t), out_time_start, abs_c(e_out[t].t_start));
                check($sformatf("%s.end@%0d", name, t), out_time_end, abs_c(e_out[t].t_end));
                check($sformatf("%s.stale@%0d", name, t), out_stale, e_out[t].stale);
                check($sformatf("%s.timeout@%0d", name, t), out_timeout, e_out[t].tmo);
            end
            counter = abs_c(t); in_valid = s_valid[t]; in_pass_through = s_pt[t];
            in_time_end = abs_c(s_end[t]); in_tag = s_tag[t]; stage_ready = s_rdy[t];
            @(negedge clk);
        end
        in_valid = 0; stage_ready = 0;
    endtask

    task automatic fill_random(input int len, input logic [CW-1:0] b, input int pct_valid);
        clear(len, b);
        for (int t = 0; t < len - 40; t++) begin
            s_valid[t] = ($urandom_range(0, 99) < pct_valid);
            s_pt[t]    = ($urandom_range(0, 3) == 0);
            s_end[t]   = t - int'($urandom_range(1, 30));
            s_tag[t]   = TW'($urandom);
        end
        for (int t = 0; t < len; t++) s_rdy[t] = ($urandom_range(0, 99) < 15);
    endtask

    initial begin
        rst = 1'b0; counter = '0; in_valid = 0; in_pass_through = 0;
        in_time_end = '0; in_tag = '0; stage_ready = 0;

        // Pass-through: tag 5, E=100 pushed at counter 10.
        clear(24, '0);
        s_valid[10] = 1; s_pt[10] = 1; s_end[10] = 100; s_tag[10] = 16'd5;
        reset_dut(); run_phase("pass");
        check("pass.no_early", obs_valid[12], 0);
        check("pass.valid13", obs_valid[13], 1);
        check("pass.start", obs_start[13], 100);
        check("pass.end", obs_end[13], 100);
        check("pass.pt", obs_pt[13], 1);

        // History hit: strobes at 102 and 104, two elements with E=101.
        clear(130, '0);
        s_rdy[102] = 1; s_rdy[104] = 1;
        s_valid[106] = 1; s_end[106] = 101; s_tag[106] = 16'd1;
        s_valid[107] = 1; s_end[107] = 101; s_tag[107] = 16'd2;
        reset_dut(); run_phase("hist");
        check("hist.valid1", obs_valid[109], 1);
        check("hist.start1", obs_start[109], 102);
        check("hist.end1", obs_end[109], 102);
        check("hist.end2", obs_end[112], 104);

        // Wait: E=200 pushed at 201, strobe at 210.
        clear(230, '0);
        s_valid[201] = 1; s_end[201] = 200; s_tag[201] = 16'h33; s_rdy[210] = 1;
        reset_dut(); run_phase("wait");
        check("wait.no_early", obs_valid[210], 0);
        check("wait.valid", obs_valid[211], 1);
        check("wait.end", obs_end[211], 210);

        // Stale: E=0 pushed at 40; the strobe at 20 is outside the look-back window.
        clear(60, '0);
        s_rdy[5] = 1; s_rdy[20] = 1; s_rdy[30] = 1;
        s_valid[40] = 1; s_end[40] = 0; s_tag[40] = 16'h44;
        reset_dut(); run_phase("stale");
        check("stale.valid", obs_valid[43], 1);
        check("stale.flag", obs_stale[43], 1);
        check("stale.end", obs_end[43], 30);

        // Counter wrap: E=2^32-2, strobe at counter 1.
        clear(30, 32'hFFFF_FFF6);
        s_valid[9] = 1; s_end[9] = 8; s_tag[9] = 16'h55; s_rdy[11] = 1;
        reset_dut(); run_phase("wrap");
        check("wrap.valid", obs_valid[12], 1);
        check("wrap.start", obs_start[12], 32'hFFFF_FFFF);
        check("wrap.end", obs_end[12], 1);

        // Full: one element parked in WAIT, then five pushes; the fifth is dropped.
        clear(120, '0);
        s_valid[2] = 1; s_end[2] = 1; s_tag[2] = 16'h60;
        for (int t = 5; t <= 9; t++) begin
            s_valid[t] = 1; s_end[t] = t - 1; s_tag[t] = TW'(16'h60 + t);
        end
        s_rdy[40] = 1; s_rdy[50] = 1; s_rdy[60] = 1; s_rdy[70] = 1; s_rdy[80] = 1;
        reset_dut(); run_phase("full");
        check("full.in_ready9", obs_rdy[9], 0);
        check("full.overflow", obs_ovf[10], 1);
`ifdef STAGE_TRACKER_TIMEOUT_EN
        check("full.timeout", obs_tmo[13], 1);
        check("full.timeout_end", obs_end[13], 12);
`else
        check("full.wait_valid", obs_valid[41], 1);
        check("full.wait_end", obs_end[41], 40);
`endif

        // Random traffic, including a run across the counter wrap; each phase resets mid-flight.
        fill_random(400, CW'($urandom), 30);        reset_dut(); run_phase("rand0");
        fill_random(400, 32'hFFFF_FF00, 35);        reset_dut(); run_phase("rand1");
        fill_random(400, CW'($urandom), 60);        reset_dut(); run_phase("rand2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
